// File: rtl/iq_dispatch_pkg.sv
// Shared types for the instruction-queue dispatch path: instruction type codes and
// the three payload views of a queue entry.
package iq_dispatch_pkg;

  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'b00;
  localparam logic [1:0] INSTR_TYPE_RAM        = 2'b01;
  localparam logic [1:0] INSTR_TYPE_LOAD_STORE = 2'b10;
  localparam logic [1:0] INSTR_TYPE_ILLEGAL    = 2'b11;

  localparam logic [3:0] MATH_OP_ADD  = 4'd0;
  localparam logic [3:0] MATH_OP_MUL  = 4'd1;
  localparam logic [3:0] MATH_OP_RELU = 4'd2;

  typedef struct packed {
    logic [3:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } math_instr;

  typedef struct packed {
    logic        to_ram;
    logic [15:0] addr;
    logic [7:0]  len;
  } dma_instruction;

  typedef struct packed {
    logic        is_store;
    logic [4:0]  reg_idx;
    logic [11:0] addr;
  } regfile_instruction;

  function automatic logic is_legal_type(input logic [1:0] t);
    return t != INSTR_TYPE_ILLEGAL;
  endfunction

endpackage

// File: rtl/dispatch_skid_buf.sv
// Small in-order FIFO holding {type, payload views} between the queue read port
// and the unit ports; clear empties it in one cycle.
module dispatch_skid_buf
  import iq_dispatch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [1:0]                   push_type,
  input  math_instr                    push_math,
  input  dma_instruction               push_dma,
  input  regfile_instruction           push_cache,
  input  logic                         pop,
  output logic [1:0]                   head_type,
  output math_instr                    head_math,
  output dma_instruction               head_dma,
  output regfile_instruction           head_cache,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]         type_mem  [DEPTH];
  math_instr          math_mem  [DEPTH];
  dma_instruction     dma_mem   [DEPTH];
  regfile_instruction cache_mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage needs no reset: occ gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) begin
      type_mem[wr_ptr]  <= push_type;
      math_mem[wr_ptr]  <= push_math;
      dma_mem[wr_ptr]   <= push_dma;
      cache_mem[wr_ptr] <= push_cache;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  assign head_type  = type_mem[rd_ptr];
  assign head_math  = math_mem[rd_ptr];
  assign head_dma   = dma_mem[rd_ptr];
  assign head_cache = cache_mem[rd_ptr];

  a_occ_bound: assert property (@(posedge clk) disable iff (!reset) occ <= OW'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && occ == OW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !(pop && occ == '0));

endmodule

// File: rtl/iq_dispatch.sv
// Read side of the instruction queue: pops entries under a credit rule and routes
// the buffer head, in program order, to the math, DMA or cache unit.
//
// Unit handshake: an entry transfers on a cycle where *_valid && *_ready; once
// *_valid rises it stays high with a stable payload until that transfer happens.
module iq_dispatch
  import iq_dispatch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iq_empty,
  output logic               iq_re,
  input  logic [1:0]         iq_instr_type,
  input  math_instr          iq_math_instr,
  input  dma_instruction     iq_dma_instr,
  input  regfile_instruction iq_cache_instr,
  output logic               math_valid,
  input  logic               math_ready,
  output math_instr          math_instr_o,
  output logic               dma_valid,
  input  logic               dma_ready,
  output dma_instruction     dma_instr_o,
  output logic               cache_valid,
  input  logic               cache_ready,
  output regfile_instruction cache_instr_o,
  input  logic               flush,
  output logic               idle,
  output logic               illegal_type
);

  localparam int OW = $clog2(BUF_DEPTH + 1);

  logic               inflight;
  logic [OW-1:0]      occ;
  logic [1:0]         head_type;
  math_instr          head_math;
  dma_instruction     head_dma;
  regfile_instruction head_cache;
  logic               capture;
  logic               head_live;
  logic               pop;
  logic [OW:0]        credit;

  assign capture   = inflight && !flush && is_legal_type(iq_instr_type);
  assign head_live = (occ != '0) && !flush;

  assign math_valid  = head_live && (head_type == INSTR_TYPE_ARITHMETIC);
  assign dma_valid   = head_live && (head_type == INSTR_TYPE_RAM);
  assign cache_valid = head_live && (head_type == INSTR_TYPE_LOAD_STORE);

  assign pop = (math_valid && math_ready) || (dma_valid && dma_ready) ||
               (cache_valid && cache_ready);

  // Entries already requested must still fit once they land, so in-flight reads
  // count against the buffer; a same-cycle pop frees a slot.
  assign credit = {1'b0, occ} + (OW + 1)'(inflight) - (OW + 1)'(pop);
  assign iq_re  = reset && !iq_empty && !flush && (credit < (OW + 1)'(BUF_DEPTH));

  assign math_instr_o  = math_valid  ? head_math  : '0;
  assign dma_instr_o   = dma_valid   ? head_dma   : '0;
  assign cache_instr_o = cache_valid ? head_cache : '0;

  assign idle = iq_empty && (occ == '0) && !inflight;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight     <= 1'b0;
      illegal_type <= 1'b0;
    end else begin
      inflight <= iq_re;
      if (inflight && !flush && !is_legal_type(iq_instr_type)) illegal_type <= 1'b1;
    end
  end

  dispatch_skid_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .push       (capture),
    .push_type  (iq_instr_type),
    .push_math  (iq_math_instr),
    .push_dma   (iq_dma_instr),
    .push_cache (iq_cache_instr),
    .pop        (pop),
    .head_type  (head_type),
    .head_math  (head_math),
    .head_dma   (head_dma),
    .head_cache (head_cache),
    .occ        (occ)
  );

endmodule
